// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the mult_sched round-robin multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    // Tag width: at least one bit even for a single requester.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_sched_booth.sv
// Combinational radix-4 Booth multiplier, full 2*WIDTH signed product (WIDTH even).
module booth_mult #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] ae;
    logic signed [2*WIDTH-1:0] pp;
    logic signed [2*WIDTH-1:0] acc;
    logic        [WIDTH:0]     bx;
    logic        [2:0]         trip;

    always_comb begin
        ae   = {{WIDTH{a[WIDTH-1]}}, a};
        bx   = {b, 1'b0};
        acc  = '0;
        pp   = '0;
        trip = '0;
        // Each overlapping triplet of b selects a digit in {-2,-1,0,1,2}.
        for (int unsigned i = 0; i < WIDTH / 2; i++) begin
            trip = bx[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae <<< 1;
                3'b100:         pp = -(ae <<< 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * i));
        end
        p = acc;
    end

endmodule

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [id_w(NREQ)-1:0]   ptr,
    output logic [NREQ-1:0]         gnt
);

    localparam int unsigned N = NREQ;

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin multiplier scheduler: IDLE/CALC/DONE, one operation in flight.
// Optional MULT_SCHED_STATS_EN adds a saturating op_count result counter.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_y,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*WIDTH-1:0]      res_p,
    output logic [id_w(NREQ)-1:0]   res_id
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [15:0]             op_count
`endif
);

    localparam int          IDW = id_w(NREQ);
    localparam int unsigned N   = NREQ;

    state_t                    state;
    logic signed [WIDTH-1:0]   x_q;
    logic signed [WIDTH-1:0]   y_q;
    logic [IDW-1:0]            tag_q;
    logic [IDW-1:0]            rr_ptr;
    logic [NREQ-1:0]           gnt;
    logic signed [2*WIDTH-1:0] prod;
    logic                      hs;
    logic [WIDTH-1:0]          sel_x;
    logic [WIDTH-1:0]          sel_y;
    logic [IDW-1:0]            sel_id;
    logic [IDW-1:0]            nxt_ptr;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    booth_mult #(.WIDTH(WIDTH)) u_mul (
        .a (x_q),
        .b (y_q),
        .p (prod)
    );

    assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

    always_comb begin
        hs      = |(req_valid & req_ready);
        sel_x   = '0;
        sel_y   = '0;
        sel_id  = '0;
        nxt_ptr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_x   = req_x[i*WIDTH +: WIDTH];
                sel_y   = req_y[i*WIDTH +: WIDTH];
                sel_id  = IDW'(i);
                nxt_ptr = (i + 1 == N) ? '0 : IDW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            tag_q     <= '0;
            rr_ptr    <= '0;
            res_valid <= 1'b0;
            res_p     <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        x_q    <= sel_x;
                        y_q    <= sel_y;
                        tag_q  <= sel_id;
                        rr_ptr <= nxt_ptr;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    res_p     <= prod;
                    res_id    <= tag_q;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (state == DONE && res_ready && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: vector table, directed corner sequences, random vs model.
module tb_mult_sched;

    localparam int W = 8;
    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic             res_valid;
    logic             res_ready;
    logic [2*W-1:0]   res_p;
    logic [0:0]       res_id;
`ifdef MULT_SCHED_STATS_EN
    logic [15:0]      op_count;
`endif

    mult_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id)
`ifdef MULT_SCHED_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int both_hi = 0;

    always @(negedge clk) if (req_ready == 2'b11) both_hi++;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic [2*W-1:0]      p;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] prod(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        longint r;
        r = longint'(a) * longint'(b);
        return r[2*W-1:0];
    endfunction

    // One full transaction: wait for grant, check 2-edge latency, optional result stall.
    task automatic run_op(input logic [N-1:0] mask, input logic [N*W-1:0] xs,
                          input logic [N*W-1:0] ys, input int stall,
                          output int gid, output logic [2*W-1:0] p);
        int n;
        logic [2*W-1:0] p0;
        logic [0:0]     id0;
        gid       = -1;
        p         = '0;
        req_valid = mask;
        req_x     = xs;
        req_y     = ys;
        res_ready = (stall == 0);
        #1;
        n = 0;
        while (!(|(req_valid & req_ready)) && n < 20) begin
            step;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout actual=none required=grant");
            req_valid = '0;
            return;
        end
        chk("ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        step;
        req_valid = '0;
        chk("lat_edge1_valid", {63'd0, res_valid}, 64'd0);
        chk("ready_in_calc", {62'd0, req_ready}, 64'd0);
        step;
        chk("lat_edge2_valid", {63'd0, res_valid}, 64'd1);
        chk("res_id", {63'd0, res_id}, 64'(gid));
        p   = res_p;
        p0  = res_p;
        id0 = res_id;
        req_valid = (stall > 0) ? 2'b11 : 2'b00;
        for (int k = 0; k < stall; k++) begin
            step;
            chk("stall_valid", {63'd0, res_valid}, 64'd1);
            chk("stall_p", {48'd0, res_p}, {48'd0, p0});
            chk("stall_id", {63'd0, res_id}, {63'd0, id0});
            chk("stall_ready", {62'd0, req_ready}, 64'd0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        step;
        chk("accept_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("accept_p_kept", {48'd0, res_p}, {48'd0, p0});
        res_ready = 1'b0;
    endtask

    initial begin
        int gid;
        int mp;
        int w;
        logic [2*W-1:0] p;
        logic [N-1:0]   mask;
        logic [N*W-1:0] xs;
        logic [N*W-1:0] ys;

        tbl[0] = '{-8'sd3,   8'sd5,    16'hFFF1};
        tbl[1] = '{-8'sd128, -8'sd128, 16'h4000};
        tbl[2] = '{8'sd127,  -8'sd128, 16'hC080};
        tbl[3] = '{8'sd127,  8'sd127,  16'h3F01};
        tbl[4] = '{-8'sd1,   -8'sd1,   16'h0001};
        tbl[5] = '{8'sd0,    -8'sd77,  16'h0000};
        tbl[6] = '{-8'sd128, 8'sd1,    16'hFF80};
        tbl[7] = '{8'sd85,   -8'sd86,  16'hE372};

        // Reset with both requesters asserting: no grant may leak out.
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b0;
        step;
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        step;
        chk("rst_ready2", {62'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_p", {48'd0, res_p}, 64'd0);
        chk("rst_id", {63'd0, res_id}, 64'd0);
`ifdef MULT_SCHED_STATS_EN
        chk("rst_op_count", {48'd0, op_count}, 64'd0);
`endif
        req_valid = '0;
        rst_n     = 1'b1;
        step;

        for (int i = 0; i < 8; i++) begin
            run_op(2'b01, {8'h00, tbl[i].x}, {8'h00, tbl[i].y}, 0, gid, p);
            chk("tbl_p", {48'd0, p}, {48'd0, tbl[i].p});
            chk("tbl_gid", 64'(gid), 64'd0);
        end

        // Both requesters continuously valid from reset: strict alternation.
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        xs = {8'sd7, -8'sd9};
        ys = {-8'sd11, 8'sd13};
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, xs, ys, 0, gid, p);
            chk("rr_order", 64'(gid), 64'(i % 2));
            if (gid >= 0 && gid < N)
                chk("rr_p", {48'd0, p}, {48'd0, prod(xs[gid*W +: W], ys[gid*W +: W])});
        end

        // Consumer holds off for 5 cycles in DONE.
        run_op(2'b10, {8'sd100, 8'sd0}, {-8'sd3, 8'sd0}, 5, gid, p);
        chk("stall5_p", {48'd0, p}, {48'd0, 16'hFED4});
        chk("stall5_gid", 64'(gid), 64'd1);

        // Reset while CALC is in flight; rr pointer first moved off 0.
        run_op(2'b01, {8'h00, 8'sd20}, {8'h00, 8'sd30}, 0, gid, p);
        chk("pre_rst_p", {48'd0, p}, {48'd0, 16'd600});
        req_valid = 2'b01;
        req_x     = {8'h00, 8'sd9};
        req_y     = {8'h00, 8'sd9};
        #1;
        chk("calc_rst_hs", {62'd0, req_ready}, 64'd1);
        step;
        req_valid = '0;
        rst_n     = 1'b0;
        step;
        rst_n = 1'b1;
        chk("calc_rst_valid", {63'd0, res_valid}, 64'd0);
        chk("calc_rst_p", {48'd0, res_p}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            step;
            chk("calc_rst_nopulse", {63'd0, res_valid}, 64'd0);
        end
        run_op(2'b11, {8'sd2, 8'sd3}, {8'sd4, 8'sd5}, 0, gid, p);
        chk("post_rst_gid", 64'(gid), 64'd0);
        chk("post_rst_p", {48'd0, p}, 64'd15);

        // Random traffic against a transaction-level round-robin model.
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        mp = 0;
        for (int it = 0; it < 60; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            xs   = (N*W)'($urandom);
            ys   = (N*W)'($urandom);
            w    = -1;
            for (int off = 0; off < N; off++)
                if (w < 0 && mask[(mp + off) % N]) w = (mp + off) % N;
            mp = (w + 1) % N;
            run_op(mask, xs, ys, int'($urandom_range(0, 3)), gid, p);
            chk("rnd_gid", 64'(gid), 64'(w));
            chk("rnd_p", {48'd0, p}, {48'd0, prod(xs[w*W +: W], ys[w*W +: W])});
        end

`ifdef MULT_SCHED_STATS_EN
        force dut.op_count = 16'hFFFD;
        #1;
        release dut.op_count;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b01, {8'h00, 8'sd3}, {8'h00, 8'sd3}, 0, gid, p);
            chk("op_count_sat", {48'd0, op_count}, (i == 0) ? 64'hFFFE : 64'hFFFF);
        end
`endif

        chk("never_both_ready", 64'(both_hi), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width, two's-complement signed, even, minimum 4.
REQ-002 The block SHALL have parameter NREQ, default 2: number of requesters, 2 to 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester operand-valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept, one-hot or zero.
REQ-007 The block SHALL have port req_x, input, NREQ*WIDTH bits: multiplicands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_y, input, NREQ*WIDTH bits: multipliers, packed the same way as req_x.
REQ-009 The block SHALL have port res_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port res_ready, input, 1 bit: result consumer accept.
REQ-011 The block SHALL have port res_p, output, 2*WIDTH bits: signed product.
REQ-012 The block SHALL have port res_id, output, max(1,$clog2(NREQ)) bits: index of the requester that owns res_p.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE, and exactly one operation SHALL be in flight at a time.
REQ-014 In IDLE with any req_valid high, the block SHALL assert req_ready combinationally, only for the round-robin winner g (first set bit at or after rr_ptr, wrapping).
REQ-015 In IDLE with no req_valid high, req_ready SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-016 req_ready SHALL be 0 in CALC and DONE.
REQ-017 On a clock edge with req_valid[g] & req_ready[g], the block SHALL latch x, y and g into operand registers, set rr_ptr to (g+1) mod NREQ, and go to CALC.
REQ-018 In CALC, on the next edge the block SHALL register the multiplier output into res_p and the tag into res_id, set res_valid to 1, and go to DONE; latency from handshake edge to res_valid high is 2 edges.
REQ-019 In DONE, res_valid, res_p and res_id SHALL hold stable while res_ready is low.
REQ-020 On an edge in DONE with res_ready high, res_valid SHALL drop to 0 and the FSM SHALL go to IDLE; res_p and res_id SHALL retain their last values.
REQ-021 Sustained throughput SHALL be one product per 3 cycles.
REQ-022 Arithmetic SHALL be a full signed product with no truncation: -2^(W-1) * -2^(W-1) = +2^(2W-2), which fits in 2W bits.
REQ-023 A requester that drops req_valid before its handshake SHALL forfeit the grant, with no state change and no change to rr_ptr.
REQ-024 When all requesters are active, each SHALL be served once per NREQ operations.

Reset
REQ-025 On an edge with rst_n low, the block SHALL set the FSM to IDLE, res_valid to 0, res_p to 0, res_id to 0, rr_ptr to 0, and operand registers to 0; req_ready SHALL therefore read 0 while rst_n is low.
REQ-026 Reset in CALC or DONE SHALL discard the in-flight operation with no res_valid pulse, and reset SHALL take priority over every handshake in the same cycle.

Configuration
REQ-027 With macro MULT_SCHED_STATS_EN defined, the block SHALL add output op_count[15:0], reset to 0, incremented on each result handshake (DONE & res_ready) and saturating at 16'hFFFF.
REQ-028 Without MULT_SCHED_STATS_EN, port op_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package mult_sched_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default WIDTH and NREQ constants.
REQ-030 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs req and ptr, output one-hot gnt), and the product SHALL come from the team's combinational radix-4 Booth multiplier instantiated with WIDTH.

Verification
REQ-031 The bench SHALL cover: WIDTH=8, req0 x=-3, y=5 -> res_valid 2 edges after handshake, res_p=16'hFFF1, res_id=0.
REQ-032 The bench SHALL cover: x=-128, y=-128 -> res_p=16'h4000; then x=127, y=-128 -> res_p=16'hC080.
REQ-033 The bench SHALL cover: both req_valid held high for 4 operations from reset -> grant order 0,1,0,1, with req_ready never 2'b11.
REQ-034 The bench SHALL cover: res_ready low for 5 cycles in DONE -> res_p and res_id stable, req_ready=0 throughout; one result accepted on release.
REQ-035 The bench SHALL cover: rst_n low for 1 edge in CALC -> no res_valid pulse, next grant goes to req0, res_p=0.
REQ-036 The bench SHALL cover, with MULT_SCHED_STATS_EN: op_count preloaded near 16'hFFFE, then 3 results -> op_count reads 16'hFFFF.
